// File: rtl/wash_sense_front.sv
// Sensor conditioning and phase timing ahead of auto_machine: debounced door/level/detergent
// status plus wash and spin phase timeouts derived from the controller's own actuator outputs.
module wash_sense_front #(
    parameter int DEB_CYCLES  = 4,
    parameter int LEVEL_W     = 8,
    parameter int FULL_LEVEL  = 200,
    parameter int EMPTY_LEVEL = 10,
    parameter int WASH_CYCLES = 16,
    parameter int SPIN_CYCLES = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_sw,
    input  logic [LEVEL_W-1:0] level_in,
    input  logic               det_sw,
    input  logic               motor_on,
    input  logic               drain_value_on,
    output logic               door_close,
    output logic               filled,
    output logic               drained,
    output logic               detergent_added,
    output logic               cycle_timeout,
    output logic               spin_timeout
);

    localparam int CH_DOOR  = 0;
    localparam int CH_FULL  = 1;
    localparam int CH_EMPTY = 2;
    localparam int CH_DET   = 3;

    localparam logic [7:0]         DEB_TGT   = 8'(DEB_CYCLES);
    localparam logic [LEVEL_W-1:0] FULL_LVL  = LEVEL_W'(FULL_LEVEL);
    localparam logic [LEVEL_W-1:0] EMPTY_LVL = LEVEL_W'(EMPTY_LEVEL);
    localparam logic [15:0]        WASH_TGT  = 16'(WASH_CYCLES);
    localparam logic [15:0]        SPIN_TGT  = 16'(SPIN_CYCLES);

    logic [3:0]  cand_q, cand_d;
    logic [3:0]  deb_q, deb_d;
    logic [7:0]  cnt_q [4];
    logic [7:0]  cnt_d [4];
    logic        det_q, det_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] scnt_q, scnt_d;
    logic        wto_q, wto_d;
    logic        sto_q, sto_d;
    logic        drained_rise;
    logic        wash_qual;
    logic        spin_qual;

    always_comb begin
        cand_d = {det_sw, (level_in <= EMPTY_LVL), (level_in >= FULL_LVL), door_sw};
    end

    // Each channel counts consecutive disagreements; any agreement or a completed run restarts it.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cand_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] + 8'd1 == DEB_TGT) begin
                deb_d[i] = cand_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // The drained rising edge clears the flag on the same edge the tank is reported empty.
    always_comb begin
        drained_rise = deb_d[CH_EMPTY] & ~deb_q[CH_EMPTY];
        det_d        = det_q;
        if (drained_rise) begin
            det_d = 1'b0;
        end else if (deb_q[CH_DET]) begin
            det_d = 1'b1;
        end
    end

    always_comb begin
        wash_qual = motor_on & ~drain_value_on & deb_q[CH_FULL];
        wcnt_d    = wcnt_q;
        wto_d     = wto_q;
        if (!motor_on) begin
            wcnt_d = '0;
            wto_d  = 1'b0;
        end else if (wash_qual && (wcnt_q != WASH_TGT)) begin
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q + 16'd1 == WASH_TGT) begin
                wto_d = 1'b1;
            end
        end
    end

    // A lost qualifier with the motor still running only pauses the count.
    always_comb begin
        spin_qual = motor_on & deb_q[CH_EMPTY];
        scnt_d    = scnt_q;
        sto_d     = sto_q;
        if (!motor_on) begin
            scnt_d = '0;
            sto_d  = 1'b0;
        end else if (spin_qual && (scnt_q != SPIN_TGT)) begin
            scnt_d = scnt_q + 16'd1;
            if (scnt_q + 16'd1 == SPIN_TGT) begin
                sto_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            det_q  <= 1'b0;
            wcnt_q <= '0;
            scnt_q <= '0;
            wto_q  <= 1'b0;
            sto_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            deb_q  <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            det_q  <= det_d;
            wcnt_q <= wcnt_d;
            scnt_q <= scnt_d;
            wto_q  <= wto_d;
            sto_q  <= sto_d;
        end
    end

    assign door_close      = deb_q[CH_DOOR];
    assign filled          = deb_q[CH_FULL];
    assign drained         = deb_q[CH_EMPTY];
    assign detergent_added = det_q;
    assign cycle_timeout   = wto_q;
    assign spin_timeout    = sto_q;

endmodule

// File: tb/tb_wash_sense_front.sv
// Directed walk through the washing sequence followed by randomized traffic, all checked
// against a history-window behavioural model of the sensor front end.
module tb_wash_sense_front;

    localparam int DEB   = 4;
    localparam int LW    = 8;
    localparam int FULL  = 200;
    localparam int EMPTY = 10;
    localparam int WASH  = 16;
    localparam int SPIN  = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          door_sw;
    logic [LW-1:0] level_in;
    logic          det_sw;
    logic          motor_on;
    logic          drain_value_on;
    logic          door_close;
    logic          filled;
    logic          drained;
    logic          detergent_added;
    logic          cycle_timeout;
    logic          spin_timeout;

    int total = 0;
    int bad   = 0;

    // Model: raw samples per channel, the last DEB registered samples, and phase edge counts.
    bit mCand [4];
    bit mDeb  [4];
    bit mHist [4][$];
    bit mDet;
    int mWash;
    int mSpin;

    int lvlTab [8] = '{0, 5, 10, 11, 150, 199, 200, 255};

    always #5 clk = ~clk;

    wash_sense_front #(
        .DEB_CYCLES (DEB),
        .LEVEL_W    (LW),
        .FULL_LEVEL (FULL),
        .EMPTY_LEVEL(EMPTY),
        .WASH_CYCLES(WASH),
        .SPIN_CYCLES(SPIN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .door_sw        (door_sw),
        .level_in       (level_in),
        .det_sw         (det_sw),
        .motor_on       (motor_on),
        .drain_value_on (drain_value_on),
        .door_close     (door_close),
        .filled         (filled),
        .drained        (drained),
        .detergent_added(detergent_added),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    // A flag switches once its last DEB registered samples all agree on the opposite value.
    task automatic modelEdge();
        bit oldDeb [4];
        bit same;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mCand[i] = 1'b0;
                mDeb[i]  = 1'b0;
                mHist[i].delete();
            end
            mDet  = 1'b0;
            mWash = 0;
            mSpin = 0;
        end else begin
            oldDeb = mDeb;
            for (int i = 0; i < 4; i++) begin
                mHist[i].push_back(mCand[i]);
                if (mHist[i].size() > DEB) void'(mHist[i].pop_front());
                if (mHist[i].size() == DEB) begin
                    same = 1'b1;
                    for (int k = 0; k < DEB; k++) begin
                        if (mHist[i][k] != mCand[i]) same = 1'b0;
                    end
                    if (same) mDeb[i] = mCand[i];
                end
            end
            if (mDeb[2] && !oldDeb[2]) mDet = 1'b0;
            else if (oldDeb[3]) mDet = 1'b1;
            if (!motor_on) mWash = 0;
            else if (!drain_value_on && oldDeb[1]) mWash++;
            if (!motor_on) mSpin = 0;
            else if (oldDeb[2]) mSpin++;
            mCand[0] = door_sw;
            mCand[1] = (int'(level_in) >= FULL);
            mCand[2] = (int'(level_in) <= EMPTY);
            mCand[3] = det_sw;
        end
    endtask

    task automatic checkOutput();
        chk("door_close", door_close, mDeb[0]);
        chk("filled", filled, mDeb[1]);
        chk("drained", drained, mDeb[2]);
        chk("detergent_added", detergent_added, mDet);
        chk("cycle_timeout", cycle_timeout, mWash >= WASH);
        chk("spin_timeout", spin_timeout, mSpin >= SPIN);
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    initial begin
        reset = 1'b1; door_sw = 1'b1; level_in = '0; det_sw = 1'b0;
        motor_on = 1'b0; drain_value_on = 1'b0;
        applyStimulus(2);
        chk("t1_reset_drained", drained, 1'b0);
        reset = 1'b0;
        applyStimulus(4);
        chk("t1_door_early", door_close, 1'b0);
        chk("t1_drained_early", drained, 1'b0);
        applyStimulus(1);
        chk("t1_door_rise", door_close, 1'b1);
        chk("t1_drained_rise", drained, 1'b1);
        chk("t1_filled", filled, 1'b0);

        door_sw = 1'b0;
        applyStimulus(5);
        chk("t2_door_open", door_close, 1'b0);
        door_sw = 1'b1;
        applyStimulus(3);
        door_sw = 1'b0;
        applyStimulus(6);
        chk("t2_glitch", door_close, 1'b0);
        door_sw = 1'b1;
        applyStimulus(4);
        chk("t2_door_4th", door_close, 1'b0);
        applyStimulus(1);
        chk("t2_door_5th", door_close, 1'b1);

        level_in = 8'd50;  applyStimulus(2);
        level_in = 8'd100; applyStimulus(2);
        level_in = 8'd150; applyStimulus(2);
        level_in = 8'd200; motor_on = 1'b1;
        applyStimulus(4);
        chk("t3_filled_early", filled, 1'b0);
        applyStimulus(1);
        chk("t3_filled_rise", filled, 1'b1);
        applyStimulus(4);
        level_in = 8'd150; applyStimulus(2);
        chk("t3_short_dip", filled, 1'b1);
        level_in = 8'd200; applyStimulus(2);
        level_in = 8'd150; applyStimulus(8);
        chk("t3_long_dip", filled, 1'b0);
        level_in = 8'd200; applyStimulus(5);
        applyStimulus(2);
        chk("t3_wash_15", cycle_timeout, 1'b0);
        applyStimulus(1);
        chk("t3_wash_16", cycle_timeout, 1'b1);
        applyStimulus(3);
        chk("t3_wash_sat", cycle_timeout, 1'b1);

        motor_on = 1'b0; applyStimulus(1);
        chk("t4_clear", cycle_timeout, 1'b0);
        motor_on = 1'b1; applyStimulus(1);
        chk("t4_restart", cycle_timeout, 1'b0);

        motor_on = 1'b0; det_sw = 1'b1;
        applyStimulus(5);
        chk("t5_det_wait", detergent_added, 1'b0);
        applyStimulus(1);
        chk("t5_det_set", detergent_added, 1'b1);
        det_sw = 1'b0; level_in = 8'd5; drain_value_on = 1'b1;
        applyStimulus(4);
        chk("t5_det_hold", detergent_added, 1'b1);
        applyStimulus(1);
        chk("t5_drained", drained, 1'b1);
        chk("t5_det_clear", detergent_added, 1'b0);
        applyStimulus(2);
        motor_on = 1'b1;
        applyStimulus(11);
        chk("t5_spin_11", spin_timeout, 1'b0);
        applyStimulus(1);
        chk("t5_spin_12", spin_timeout, 1'b1);

        motor_on = 1'b0; applyStimulus(1);
        chk("t6_spin_clear", spin_timeout, 1'b0);
        motor_on = 1'b1; applyStimulus(8);
        reset = 1'b1; applyStimulus(1);
        chk("t6_rst_door", door_close, 1'b0);
        chk("t6_rst_drained", drained, 1'b0);
        chk("t6_rst_spin", spin_timeout, 1'b0);
        reset = 1'b0;
        applyStimulus(5);
        chk("t6_drained_again", drained, 1'b1);
        applyStimulus(11);
        chk("t6_spin_11", spin_timeout, 1'b0);
        applyStimulus(1);
        chk("t6_spin_12", spin_timeout, 1'b1);

        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 5) == 0) door_sw = ~door_sw;
            if ($urandom_range(0, 5) == 0) det_sw = ~det_sw;
            if ($urandom_range(0, 5) == 0) level_in = 8'(lvlTab[$urandom_range(0, 7)]);
            if ($urandom_range(0, 19) == 0) motor_on = ~motor_on;
            if ($urandom_range(0, 9) == 0) drain_value_on = ~drain_value_on;
            applyStimulus(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
